mac_acc_seq: RTL and testbench

MAC_ACC_SEQ -- requirements
Module: mac_acc_seq

---
 rtl/mac_acc_seq_pkg.sv | 19 +
 rtl/mac_acc_seq_if.sv | 42 ++++
 rtl/mac_acc_seq_term_counter.sv | 33 +++
 rtl/mac_acc_seq.sv | 89 ++++++++
 tb/tb_mac_acc_seq.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_acc_seq_pkg.sv
// Shared types and defaults for the product accumulator.
// Holds the FSM state type and accumulator width helper.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

  localparam int DEF_N = 8;
  localparam int DEF_M = DEF_N;
  localparam int DEF_K = 4;

  function automatic int acc_w(input int n, input int m, input int k);
    return (k > 1) ? n + m + $clog2(k) : n + m;
  endfunction

endpackage

// File: rtl/mac_acc_seq_if.sv
// Product-in / sum-out handshake bundle for mac_acc_seq.
// master drives products and consumes sums; slave is the block.
interface mac_acc_seq_if
  import mac_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = N,
  parameter int K = DEF_K
);

  localparam int ACC_W = acc_w(N, M, K);
  localparam int CW    = $clog2(K + 1);

  logic [N+M-1:0]   prod;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] sum;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    term_cnt;

  modport master (
    output prod,
    output in_valid,
    input  in_ready,
    input  sum,
    input  out_valid,
    output out_ready,
    input  term_cnt
  );

  modport slave (
    input  prod,
    input  in_valid,
    output in_ready,
    output sum,
    output out_valid,
    input  out_ready,
    output term_cnt
  );

endinterface

// File: rtl/mac_acc_seq_term_counter.sv
// Counts accepted products in a group; term flags the enable
// that brings the count to K.
module term_counter #(
  parameter int K = 4,
  parameter int W = $clog2(K + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = en && (cnt_q == W'(K - 1));

endmodule

// File: rtl/mac_acc_seq.sv
// Accumulates K unsigned products into one sum and holds it
// until the consumer takes it.
module mac_acc_seq
  import mac_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = N,
  parameter int K = DEF_K
) (
  input logic          clk,
  input logic          rst,
  input logic          clr,
  mac_acc_seq_if.slave bus
);

  localparam int ACC_W = acc_w(N, M, K);
  localparam int CW    = $clog2(K + 1);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             in_fire;
  logic             out_fire;
  logic             term;
  logic [CW-1:0]    cnt;

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

  // First product of a group replaces the old sum.
  assign acc_d = (state_q == IDLE) ? ACC_W'(bus.prod)
                                   : acc_q + ACC_W'(bus.prod);

  term_counter #(
    .K(K),
    .W(CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr || out_fire),
    .en   (in_fire && !clr),
    .cnt  (cnt),
    .term (term)
  );

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE, ACC: begin
          if (in_fire) begin
            acc_q <= acc_d;
            if (term) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q <= ACC;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.sum       = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.term_cnt  = cnt;

endmodule

// File: tb/tb_mac_acc_seq.sv
// Scoreboard bench for mac_acc_seq at N=8, M=8, K=4.
module tb_mac_acc_seq;

  logic clk;
  logic rst;
  logic clr;

  int total;
  int bad;
  int xfers;
  int exp_xfers;
  logic [17:0] exp_q[$];

  mac_acc_seq_if #(.N(8), .M(8), .K(4)) bus ();

  mac_acc_seq #(
    .N(8),
    .M(8),
    .K(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && !clr && bus.out_valid && bus.out_ready) xfers++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] p0, input logic [15:0] p1,
                      input logic [15:0] p2, input logic [15:0] p3,
                      input int n, input int gap);
    logic [15:0] p[4];
    logic [17:0] s;
    logic        ov;
    p = '{p0, p1, p2, p3};
    s = '0;
    for (int i = 0; i < n; i++) s = s + {2'b00, p[i]};
    if (n == 4) exp_q.push_back(s);
    for (int i = 0; i < n; i++) begin
      bus.prod     = p[i];
      bus.in_valid = 1'b1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL feed_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.term_cnt !== 3'(i + 1)) begin
        bad++;
        $display("FAIL feed_term_cnt[%0d]: got %0d want %0d", i, bus.term_cnt, i + 1);
      end
      ov = (n == 4) && (i == 3);
      total++;
      if (bus.out_valid !== ov) begin
        bad++;
        $display("FAIL feed_out_valid[%0d]: got %b want %b", i, bus.out_valid, ov);
      end
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          total++;
          if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL gap_out_valid[%0d]: got %b want 0", i, bus.out_valid);
          end
        end
      end
    end
  endtask

  task automatic check_done(output logic [17:0] e);
    e = '0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: got 0 entries want 1");
    end else begin
      e = exp_q.pop_front();
    end
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL done_out_valid: got %b want 1", bus.out_valid);
    end
    total++;
    if (bus.sum !== e) begin
      bad++;
      $display("FAIL done_sum: got %h want %h", bus.sum, e);
    end
    total++;
    if (bus.term_cnt !== 3'd4) begin
      bad++;
      $display("FAIL done_term_cnt: got %0d want 4", bus.term_cnt);
    end
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL done_in_ready: got %b want 0", bus.in_ready);
    end
  endtask

  task automatic release_sum(input logic [17:0] e);
    bus.out_ready = 1'b1;
    exp_xfers++;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_hs: got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready);
    end
    total++;
    if (bus.term_cnt !== 3'd0) begin
      bad++;
      $display("FAIL release_term_cnt: got %0d want 0", bus.term_cnt);
    end
    total++;
    if (bus.sum !== e) begin
      bad++;
      $display("FAIL release_sum_hold: got %h want %h", bus.sum, e);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if (bus.sum !== 18'h0 || bus.out_valid !== 1'b0 || bus.term_cnt !== 3'd0) begin
      bad++;
      $display("FAIL %s: got sum=%h ov=%b tc=%0d want sum=0 ov=0 tc=0",
               tag, bus.sum, bus.out_valid, bus.term_cnt);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    clr           = 1'b0;
    bus.prod      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_reset_vals("reset_vals");
    rst = 1'b1;
    tick();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    feed(16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 4, 0);
    check_done(e);
    total++;
    if (e !== 18'h3F804) begin
      bad++;
      $display("FAIL b2b_model: got %h want 3f804", e);
    end
    release_sum(e);
    feed(16'h0003, 16'h0005, 16'h0007, 16'h0009, 4, 0);
    check_done(e);
    release_sum(e);
  endtask

  task automatic test_gaps();
    logic [17:0] e;
    feed(16'h124E, 16'h13B1, 16'h0000, 16'h0001, 4, 1);
    check_done(e);
    total++;
    if (bus.sum !== 18'h02600) begin
      bad++;
      $display("FAIL gaps_sum: got %h want 02600", bus.sum);
    end
    release_sum(e);
  endtask

  task automatic test_stall();
    logic [17:0] e;
    feed(16'h0001, 16'h0002, 16'h0003, 16'h0004, 4, 0);
    check_done(e);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.prod     = 16'hFFFF;
      tick();
      total++;
      if (bus.sum !== e || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1
          || bus.term_cnt !== 3'd4) begin
        bad++;
        $display("FAIL stall[%0d]: got sum=%h ir=%b ov=%b tc=%0d want sum=%h ir=0 ov=1 tc=4",
                 c, bus.sum, bus.in_ready, bus.out_valid, bus.term_cnt, e);
      end
    end
    bus.in_valid = 1'b0;
    release_sum(e);
  endtask

  task automatic test_clr();
    logic [17:0] e;
    feed(16'h5555, 16'hAAAA, 16'h0, 16'h0, 2, 0);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.prod     = 16'h7777;
    tick();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_vals("clr_vals");
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL clr_in_ready: got %b want 1", bus.in_ready);
    end
    feed(16'h0010, 16'h0010, 16'h0010, 16'h0010, 4, 0);
    check_done(e);
    total++;
    if (bus.sum !== 18'h00040) begin
      bad++;
      $display("FAIL clr_residue: got %h want 00040", bus.sum);
    end
    release_sum(e);
  endtask

  task automatic test_rst_mid();
    logic [17:0] e;
    feed(16'h0100, 16'h0200, 16'h0, 16'h0, 2, 0);
    bus.in_valid = 1'b1;
    bus.prod     = 16'h0007;
    rst          = 1'b0;
    tick();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    check_reset_vals("rst_acc_vals");
    tick();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_acc_in_ready: got %b want 1", bus.in_ready);
    end
    feed(16'h0101, 16'h0101, 16'h0101, 16'h0101, 4, 0);
    check_done(e);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    check_reset_vals("rst_done_vals");
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_done_after: got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_clr_done();
    logic [17:0] e;
    feed(16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 4, 0);
    check_done(e);
    clr           = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    clr           = 1'b0;
    bus.out_ready = 1'b0;
    check_reset_vals("clr_done_vals");
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL clr_done_idle[%0d]: got ov=%b ir=%b want ov=0 ir=1",
                 c, bus.out_valid, bus.in_ready);
      end
    end
    feed(16'h0002, 16'h0002, 16'h0002, 16'h0002, 4, 0);
    check_done(e);
    release_sum(e);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    xfers     = 0;
    exp_xfers = 0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_stall();
    test_clr();
    test_rst_mid();
    test_clr_done();
    total++;
    if (xfers != exp_xfers) begin
      bad++;
      $display("FAIL out_xfer_count: got %0d want %0d", xfers, exp_xfers);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
